// File: rtl/uart_tx_dump.sv
// Drains a WORDS x 32-bit message buffer onto a UART TX line as 8N1 frames.
// Words are unpacked little-endian; the dump ends after TERM or the last buffer byte.
module uart_tx_dump #(
    parameter int          CLK_DIV = 434,
    parameter int          WORDS   = 16,
    parameter logic [7:0]  TERM    = 8'h21
) (
    input  logic                      clk_sys_i,
    input  logic                      rst_sys_i,
    input  logic                      uart_start_i,
    input  logic [31:0]               uart_data_i,
    output logic [$clog2(WORDS)+1:0]  uart_data_addr_o,
    output logic                      uart_tx_o,
    output logic                      uart_busy_o,
    output logic                      uart_finish_o
);

    localparam int              AW        = $clog2(WORDS) + 2;
    localparam int              BW        = $clog2(CLK_DIV);
    localparam logic [AW-1:0]   LAST_ADDR = AW'((WORDS - 1) * 4);
    localparam logic [BW-1:0]   BAUD_LAST = BW'(CLK_DIV - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_LOAD,
        S_START,
        S_DATA,
        S_STOP,
        S_DONE
    } state_t;

    state_t          state_reg, state_next;
    logic [AW-1:0]   addr_reg, addr_next;
    logic [1:0]      byte_idx_reg, byte_idx_next;
    logic [2:0]      bit_cnt_reg, bit_cnt_next;
    logic [BW-1:0]   baud_cnt_reg, baud_cnt_next;
    logic [31:0]     word_reg, word_next;
    logic            tx_reg, tx_next;
    logic            busy_reg, busy_next;
    logic            finish_reg, finish_next;

    logic            baud_done;
    logic [7:0]      lane [4];
    logic [7:0]      cur_byte;
    logic [7:0]      next_byte;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign lane[gi] = word_reg[gi*8 +: 8];
        end
    endgenerate

    assign baud_done = (baud_cnt_reg == BAUD_LAST);
    assign cur_byte  = lane[byte_idx_reg];
    assign next_byte = lane[byte_idx_next];

    always_ff @(posedge clk_sys_i) begin
        if (rst_sys_i) begin
            state_reg    <= S_IDLE;
            addr_reg     <= '0;
            byte_idx_reg <= 2'd0;
            bit_cnt_reg  <= 3'd0;
            baud_cnt_reg <= '0;
            word_reg     <= '0;
            tx_reg       <= 1'b1;
            busy_reg     <= 1'b0;
            finish_reg   <= 1'b0;
        end else begin
            state_reg    <= state_next;
            addr_reg     <= addr_next;
            byte_idx_reg <= byte_idx_next;
            bit_cnt_reg  <= bit_cnt_next;
            baud_cnt_reg <= baud_cnt_next;
            word_reg     <= word_next;
            tx_reg       <= tx_next;
            busy_reg     <= busy_next;
            finish_reg   <= finish_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE, S_DONE: if (uart_start_i) state_next = S_FETCH;
            S_FETCH:        state_next = S_LOAD;
            S_LOAD:         state_next = S_START;
            S_START:        if (baud_done) state_next = S_DATA;
            S_DATA:         if (baud_done && bit_cnt_reg == 3'd7) state_next = S_STOP;
            S_STOP: begin
                // The last byte of the buffer forces DONE so the address never wraps.
                if (baud_done) begin
                    if (cur_byte == TERM || (byte_idx_reg == 2'd3 && addr_reg == LAST_ADDR))
                        state_next = S_DONE;
                    else if (byte_idx_reg != 2'd3)
                        state_next = S_START;
                    else
                        state_next = S_FETCH;
                end
            end
            default:        state_next = S_IDLE;
        endcase
    end

    always_comb begin
        addr_next     = addr_reg;
        byte_idx_next = byte_idx_reg;
        bit_cnt_next  = 3'd0;
        baud_cnt_next = '0;
        word_next     = word_reg;
        busy_next     = busy_reg;
        finish_next   = finish_reg;

        if (state_reg == S_START || state_reg == S_DATA || state_reg == S_STOP)
            baud_cnt_next = baud_done ? '0 : baud_cnt_reg + 1'b1;
        if (state_reg == S_DATA)
            bit_cnt_next = baud_done ? bit_cnt_reg + 3'd1 : bit_cnt_reg;

        case (state_reg)
            S_IDLE, S_DONE: begin
                if (uart_start_i) begin
                    addr_next     = '0;
                    byte_idx_next = 2'd0;
                    finish_next   = 1'b0;
                    busy_next     = 1'b1;
                end
            end
            S_LOAD: word_next = uart_data_i;
            S_STOP: begin
                if (baud_done) begin
                    case (state_next)
                        S_START: byte_idx_next = byte_idx_reg + 2'd1;
                        S_FETCH: begin
                            addr_next     = addr_reg + AW'(4);
                            byte_idx_next = 2'd0;
                        end
                        S_DONE: begin
                            finish_next = 1'b1;
                            busy_next   = 1'b0;
                        end
                        default: ;
                    endcase
                end
            end
            default: ;
        endcase

        // Line level is registered, so it is derived from where the FSM goes next.
        tx_next = 1'b1;
        if (state_next == S_START)
            tx_next = 1'b0;
        else if (state_next == S_DATA)
            tx_next = next_byte[bit_cnt_next];
    end

    assign uart_data_addr_o = addr_reg;
    assign uart_tx_o        = tx_reg;
    assign uart_busy_o      = busy_reg;
    assign uart_finish_o    = finish_reg;

endmodule

// File: tb/tb_uart_tx_dump.sv
// Bench for uart_tx_dump: expected frames and addresses are queued by the stimulus
// and consumed by a line decoder / address monitor stepped on every falling edge.
module tb_uart_tx_dump;

    localparam int C     = 4;
    localparam int WORDS = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [31:0] ram_q;
    logic [5:0]  addr;
    logic        tx, busy, finish;
    logic [31:0] mem [WORDS];

    always #5 clk = ~clk;

    always @(posedge clk) ram_q <= mem[addr[5:2]];

    uart_tx_dump #(.CLK_DIV(C), .WORDS(WORDS), .TERM(8'h21)) dut (
        .clk_sys_i        (clk),
        .rst_sys_i        (rst),
        .uart_start_i     (start),
        .uart_data_i      (ram_q),
        .uart_data_addr_o (addr),
        .uart_tx_o        (tx),
        .uart_busy_o      (busy),
        .uart_finish_o    (finish)
    );

    int          compared = 0;
    int          mismatched = 0;
    logic [7:0]  exp_q[$];
    logic [5:0]  exp_addr_q[$];
    logic [5:0]  last_exp_addr = 6'd0;
    logic [5:0]  prev_addr = 6'd0;
    int          max_addr = 0;
    int          overlap = 0;
    bit          mon_active = 1'b0;
    int          mon_cnt = 0;
    logic [7:0]  mon_shift = 8'h00;

    task automatic check(input string name, input int act, input int req);
        compared++;
        if (act != req) begin
            mismatched++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, act, req);
        end
    endtask

    task automatic monitor_step();
        if (busy && finish) overlap++;
        if (int'(addr) > max_addr) max_addr = int'(addr);
        if (addr != prev_addr) begin
            if (exp_addr_q.size() == 0) begin
                compared++;
                mismatched++;
                $display("FAIL addr_unexpected: got %0d required no change", addr);
            end else begin
                check("addr_step", addr, exp_addr_q.pop_front());
            end
            prev_addr = addr;
        end
        if (rst) begin
            mon_active = 1'b0;
        end else if (!mon_active) begin
            if (tx == 1'b0) begin
                mon_active = 1'b1;
                mon_cnt = 0;
            end
        end else begin
            mon_cnt++;
            if (mon_cnt > C && mon_cnt < 9*C && (mon_cnt % C) == C/2) begin
                mon_shift = {tx, mon_shift[7:1]};
            end else if (mon_cnt == 9*C + C/2) begin
                check("stop_bit", tx, 1);
                if (exp_q.size() == 0) begin
                    compared++;
                    mismatched++;
                    $display("FAIL frame_unexpected: got 0x%0h required none", mon_shift);
                end else begin
                    check("frame_byte", mon_shift, exp_q.pop_front());
                end
                mon_active = 1'b0;
            end
        end
    endtask

    task automatic tick();
        @(negedge clk);
        monitor_step();
    endtask

    task automatic push_word(input logic [31:0] w, input int nbytes);
        for (int b = 0; b < nbytes; b++) exp_q.push_back(w[b*8 +: 8]);
    endtask

    task automatic push_addr(input logic [5:0] a);
        if (a != last_exp_addr) exp_addr_q.push_back(a);
        last_exp_addr = a;
    endtask

    // Pulse start (E0 lies between the two ticks), then count falling edges to finish.
    task automatic run(input string name, input int exp_cycles, input bit extra_starts,
                       input int rst_at);
        int n;
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        check({name, "_finish_clear"}, finish, 0);
        check({name, "_busy_set"}, busy, 1);
        n = 0;
        while (!finish && n < exp_cycles + 50) begin
            if (rst_at > 0 && n == rst_at) begin
                rst = 1'b1;
                tick();
                check({name, "_rst_tx"}, tx, 1);
                check({name, "_rst_busy"}, busy, 0);
                check({name, "_rst_addr"}, addr, 0);
                check({name, "_rst_finish"}, finish, 0);
                rst = 1'b0;
                last_exp_addr = 6'd0;
                check({name, "_rst_pending"}, exp_q.size(), 0);
                return;
            end
            start = extra_starts && (n == 50 || n == 61);
            tick();
            n++;
        end
        start = 1'b0;
        check({name, "_finish_cycle"}, n, exp_cycles);
        check({name, "_busy_done"}, busy, 0);
        check({name, "_pending_frames"}, exp_q.size(), 0);
        check({name, "_pending_addrs"}, exp_addr_q.size(), 0);
    endtask

    initial begin
        int lows;
        logic [31:0] w;
        for (int i = 0; i < WORDS; i++) mem[i] = 32'h30303030;

        rst = 1'b1;
        tick();
        tick();
        check("reset_tx", tx, 1);
        check("reset_busy", busy, 0);
        check("reset_finish", finish, 0);
        check("reset_addr", addr, 0);
        rst = 1'b0;
        lows = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (!tx) lows++;
        end
        check("idle_line_high", lows, 0);

        // "ABC!" in word 0
        mem[0] = 32'h21434241;
        push_word(32'h21434241, 4);
        run("abc", 162, 1'b0, 0);

        // Terminator in word 2 byte 0
        mem[0] = 32'h30303030;
        mem[1] = 32'h30303030;
        mem[2] = 32'h30303021;
        push_word(32'h30303030, 4);
        push_word(32'h30303030, 4);
        push_word(32'h30303021, 1);
        push_addr(6'd4);
        push_addr(6'd8);
        run("term_w2", 366, 1'b0, 0);

        // Extra starts during frame 2 are ignored
        mem[0] = 32'h21434241;
        push_addr(6'd0);
        push_word(32'h21434241, 4);
        run("ignore_start", 162, 1'b1, 0);

        // Restart straight from DONE
        push_word(32'h21434241, 4);
        run("restart", 162, 1'b0, 0);

        // No terminator: whole buffer
        for (int i = 0; i < WORDS; i++) begin
            w = {8'(8'h80 + i), 8'(8'h60 + i), 8'(8'h40 + i), 8'(8'h10 + i)};
            mem[i] = w;
            push_word(w, 4);
            push_addr(6'(i * 4));
        end
        max_addr = 0;
        run("full", 2592, 1'b0, 0);
        check("full_max_addr", max_addr, 60);

        // Reset in the middle of frame 2 data bits, then a clean resend
        mem[0] = 32'h21434241;
        push_addr(6'd0);
        push_word(32'h21434241, 1);
        run("mid_reset", 162, 1'b0, 55);
        push_word(32'h21434241, 4);
        run("after_reset", 162, 1'b0, 0);

        check("busy_finish_overlap", overlap, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
